// File: rtl/filter_input_arbiter.sv
// Purpose: two-port AXI4-Stream input arbiter for the packet filter. Arbitration is round-robin and works on whole packets.
// Latency: 0 cycles for the data path, which is combinational from the granted port. One idle cycle between packets.
// Backpressure: the granted port's tready follows m_axis_tready. The non-granted port is held with tready = 0.
//
// Ports:
//   axi_aclk, axi_areset         clock; synchronous active-high reset
//   s0_axis_*, s1_axis_*         slave streams (tdata/tstrb/tuser/tvalid/tlast in, tready out)
//   m_axis_*                     master stream toward the filter (tready in)
//   port_enable[1:0]             per-port arbitration enable, sampled only while idle
//   pkt_count0/1                 packets forwarded per port, 32-bit wrapping
//   grant[1:0]                   one-hot current grant, 00 when idle
module filter_input_arbiter #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128
) (
   input  logic                              axi_aclk,
   input  logic                              axi_areset,

   input  logic [C_AXIS_DATA_WIDTH-1:0]      s0_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s0_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]     s0_axis_tuser,
   input  logic                              s0_axis_tvalid,
   input  logic                              s0_axis_tlast,
   output logic                              s0_axis_tready,

   input  logic [C_AXIS_DATA_WIDTH-1:0]      s1_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s1_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]     s1_axis_tuser,
   input  logic                              s1_axis_tvalid,
   input  logic                              s1_axis_tlast,
   output logic                              s1_axis_tready,

   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,

   input  logic [1:0]                        port_enable,
   output logic [31:0]                       pkt_count0,
   output logic [31:0]                       pkt_count1,
   output logic [1:0]                        grant
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_FORWARD = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;        // index of the port that finished the most recent packet
   logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [31:0] pkt_cnt1_q, pkt_cnt1_d;

   logic [1:0]  cand;
   logic [1:0]  pick;
   logic        pkt_done;

   assign cand = port_enable & {s1_axis_tvalid, s0_axis_tvalid};

   // On a tie, grant the port that was not served last. With a single
   // candidate, cand is already a one-hot grant.
   assign pick = (cand == 2'b11) ? (last_q ? 2'b01 : 2'b10) : cand;

   assign pkt_done = (state_q == ST_FORWARD) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // State register
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q    <= ST_IDLE;
         grant_q    <= 2'b00;
         last_q     <= 1'b1;           // port 0 wins the first tie after reset
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      case (state_q)
         ST_IDLE: begin
            if (|cand) begin
               state_d = ST_FORWARD;
               grant_d = pick;
            end
         end
         ST_FORWARD: begin
            // port_enable is ignored here so that a packet in progress always completes
            if (pkt_done) begin
               state_d = ST_IDLE;
               grant_d = 2'b00;
               last_d  = grant_q[1];
               if (grant_q[1]) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
               else            pkt_cnt0_d = pkt_cnt0_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // Output logic: combinational mux of the granted port while forwarding
   always_comb begin
      m_axis_tdata   = '0;
      m_axis_tstrb   = '0;
      m_axis_tuser   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      if (state_q == ST_FORWARD) begin
         if (grant_q[1]) begin
            m_axis_tdata   = s1_axis_tdata;
            m_axis_tstrb   = s1_axis_tstrb;
            m_axis_tuser   = s1_axis_tuser;
            m_axis_tvalid  = s1_axis_tvalid;
            m_axis_tlast   = s1_axis_tlast;
            s1_axis_tready = m_axis_tready;
         end else begin
            m_axis_tdata   = s0_axis_tdata;
            m_axis_tstrb   = s0_axis_tstrb;
            m_axis_tuser   = s0_axis_tuser;
            m_axis_tvalid  = s0_axis_tvalid;
            m_axis_tlast   = s0_axis_tlast;
            s0_axis_tready = m_axis_tready;
         end
      end
   end

   assign grant      = grant_q;
   assign pkt_count0 = pkt_cnt0_q;
   assign pkt_count1 = pkt_cnt1_q;

endmodule

// File: tb/tb_filter_input_arbiter.sv
module tb_filter_input_arbiter;
   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          axi_areset;
   logic [DW-1:0] s_dat  [2];
   logic [SW-1:0] s_strb [2];
   logic [UW-1:0] s_user [2];
   logic          s_vld  [2];
   logic          s_last [2];
   logic          s0_rdy, s1_rdy;
   logic [DW-1:0] m_dat;
   logic [SW-1:0] m_strb;
   logic [UW-1:0] m_user;
   logic          m_vld, m_last, m_rdy;
   logic [1:0]    port_enable;
   logic [31:0]   cnt0, cnt1;
   logic [1:0]    grant;

   always #5 clk = ~clk;

   filter_input_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) dut (
      .axi_aclk(clk), .axi_areset(axi_areset),
      .s0_axis_tdata(s_dat[0]), .s0_axis_tstrb(s_strb[0]), .s0_axis_tuser(s_user[0]),
      .s0_axis_tvalid(s_vld[0]), .s0_axis_tlast(s_last[0]), .s0_axis_tready(s0_rdy),
      .s1_axis_tdata(s_dat[1]), .s1_axis_tstrb(s_strb[1]), .s1_axis_tuser(s_user[1]),
      .s1_axis_tvalid(s_vld[1]), .s1_axis_tlast(s_last[1]), .s1_axis_tready(s1_rdy),
      .m_axis_tdata(m_dat), .m_axis_tstrb(m_strb), .m_axis_tuser(m_user),
      .m_axis_tvalid(m_vld), .m_axis_tlast(m_last), .m_axis_tready(m_rdy),
      .port_enable(port_enable), .pkt_count0(cnt0), .pkt_count1(cnt1), .grant(grant)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: a busy flag, the served port and per-port packet counters
   bit          mdl_busy;
   int          mdl_port;
   int          mdl_last;
   logic [31:0] mdl_cnt [2];

   // Sources: each port holds a queue of packet lengths; beat is the index of the presented beat
   int pk_q [2][$];
   int beat [2];
   bit hold [2];

   // Scenario knobs
   bit vld_rand;
   int rdy_mode;     // 0: always ready, 1: toggle, 2: random
   int en_clr_at;    // >0: clear port_enable[0] once this many port-0 beats of the packet are accepted
   int rst_at;       // >=0: reset while port 1 presents this beat of its second packet
   bit rst_fired;
   int served [$];   // port of every packet end seen on the DUT output
   bit prev_stall;
   logic [DW-1:0] prev_dat;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      mdl_busy   = 0;
      mdl_port   = 0;
      mdl_last   = 1;
      mdl_cnt[0] = '0;
      mdl_cnt[1] = '0;
      prev_stall = 0;
      served.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      axi_areset = 1'b1;
      for (int p = 0; p < 2; p++) begin
         pk_q[p].delete();
         beat[p]   = 0;
         hold[p]   = 0;
         s_vld[p]  = 1'b0;
         s_last[p] = 1'b0;
      end
      m_rdy = 1'b1;
      vld_rand = 0; rdy_mode = 0; en_clr_at = 0; rst_at = -1;
      @(negedge clk);
      @(negedge clk);
      axi_areset = 1'b0;
      mdl_reset();
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_mvld", m_vld, 1'b0);
      chk("rst_rdy", {s1_rdy, s0_rdy}, 2'b00);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
   endtask

   task automatic drive();
      for (int p = 0; p < 2; p++) begin
         if (pk_q[p].size() == 0) begin
            s_vld[p]  = 1'b0;
            s_last[p] = 1'b0;
            hold[p]   = 0;
         end else begin
            if (!hold[p]) begin
               // A new beat: fresh payload, which stays fixed once valid rises
               for (int w = 0; w < DW / 32; w++) s_dat[p][w*32 +: 32] = $urandom;
               for (int w = 0; w < UW / 32; w++) s_user[p][w*32 +: 32] = $urandom;
               s_strb[p] = $urandom;
               s_vld[p]  = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            s_last[p] = (beat[p] == pk_q[p][0] - 1);
            hold[p]   = s_vld[p];
         end
      end
      case (rdy_mode)
         0:       m_rdy = 1'b1;
         1:       m_rdy = ~m_rdy;
         default: m_rdy = ($urandom_range(0, 2) != 0);
      endcase
   endtask

   task automatic check_update(input bit rst_now);
      logic          e_vld, e_last;
      logic [DW-1:0] e_dat;
      logic [SW-1:0] e_strb;
      logic [UW-1:0] e_user;
      logic [1:0]    e_rdy, e_gnt;
      bit            c0, c1;
      int            p;
      e_vld = 0; e_last = 0; e_dat = '0; e_strb = '0; e_user = '0; e_rdy = 2'b00; e_gnt = 2'b00;
      p = mdl_port;
      if (mdl_busy) begin
         e_vld  = s_vld[p];
         e_last = s_last[p];
         e_dat  = s_dat[p];
         e_strb = s_strb[p];
         e_user = s_user[p];
         e_rdy[p] = m_rdy;
         e_gnt[p] = 1'b1;
      end
      chk("grant", grant, e_gnt);
      chk("m_tvalid", m_vld, e_vld);
      chk("s_tready", {s1_rdy, s0_rdy}, e_rdy);
      chk("pkt_count0", cnt0, mdl_cnt[0]);
      chk("pkt_count1", cnt1, mdl_cnt[1]);
      if (e_vld) begin
         chk("m_tdata", m_dat, e_dat);
         chk("m_tuser", m_user, e_user);
         chk("m_tstrb", m_strb, e_strb);
         chk("m_tlast", m_last, e_last);
      end
      if (prev_stall && m_vld) chk("stall_hold", m_dat, prev_dat);
      prev_stall = m_vld && !m_rdy;
      prev_dat   = m_dat;
      if (m_vld && m_rdy && m_last) served.push_back(grant == 2'b10 ? 1 : 0);

      if (!mdl_busy) begin
         c0 = port_enable[0] && s_vld[0];
         c1 = port_enable[1] && s_vld[1];
         if (c0 && c1)  mdl_port = (mdl_last == 1) ? 0 : 1;
         else if (c0)   mdl_port = 0;
         else if (c1)   mdl_port = 1;
         mdl_busy = c0 || c1;
      end else if (e_vld && m_rdy) begin
         beat[p]++;
         hold[p] = 0;
         if (p == 0 && en_clr_at > 0 && beat[0] == en_clr_at) begin
            port_enable[0] = 1'b0;
            en_clr_at = 0;
         end
         if (beat[p] == pk_q[p][0]) begin
            void'(pk_q[p].pop_front());
            beat[p]    = 0;
            mdl_busy   = 0;
            mdl_last   = p;
            mdl_cnt[p] = mdl_cnt[p] + 32'd1;
         end
      end

      if (rst_now) begin
         mdl_reset();
         port_enable = 2'b11;
         rst_at      = -1;
         rst_fired   = 1;
      end
   endtask

   task automatic run(input int max_cyc);
      bit done;
      bit rst_now;
      done = 0;
      for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
         @(negedge clk);
         rst_now = (rst_at >= 0) && mdl_busy && mdl_port == 1 && mdl_cnt[1] != 0 && beat[1] == rst_at;
         axi_areset = rst_now;
         drive();
         #1;
         check_update(rst_now);
         done = !mdl_busy && !rst_now
             && (pk_q[0].size() == 0 || !port_enable[0])
             && (pk_q[1].size() == 0 || !port_enable[1]);
      end
      if (!done) chk("timeout", 1'b1, 1'b0);
      @(negedge clk);
      axi_areset = 1'b0;
   endtask

   initial begin
      axi_areset = 1'b1;
      port_enable = 2'b11;
      m_rdy = 1'b1;
      for (int p = 0; p < 2; p++) begin
         s_dat[p] = '0; s_strb[p] = '0; s_user[p] = '0; s_vld[p] = 1'b0; s_last[p] = 1'b0;
      end
      rst_fired = 0;
      do_reset();

      // Both ports busy, 3-beat packets: strict alternation starting with port 0
      port_enable = 2'b11;
      pk_q[0] = '{3, 3};
      pk_q[1] = '{3, 3};
      run(200);
      chk("rr_npkts", served.size(), 4);
      if (served.size() == 4) begin
         chk("rr_order0", served[0], 0);
         chk("rr_order1", served[1], 1);
         chk("rr_order2", served[2], 0);
         chk("rr_order3", served[3], 1);
      end
      chk("rr_cnt0", cnt0, 2);
      chk("rr_cnt1", cnt1, 2);

      // Single-beat packets
      do_reset();
      port_enable = 2'b11;
      pk_q[0] = '{1, 1};
      pk_q[1] = '{1};
      run(100);
      chk("sb_npkts", served.size(), 3);
      if (served.size() == 3) begin
         chk("sb_order0", served[0], 0);
         chk("sb_order1", served[1], 1);
         chk("sb_order2", served[2], 0);
      end
      chk("sb_cnt0", cnt0, 2);

      // Port 1 disabled: never granted
      do_reset();
      port_enable = 2'b01;
      pk_q[0] = '{3, 2};
      pk_q[1] = '{2};
      run(100);
      chk("dis_cnt0", cnt0, 2);
      chk("dis_cnt1", cnt1, 0);
      chk("dis_pending1", pk_q[1].size(), 1);

      // Enable dropped mid-packet: the packet completes, nothing more from port 0
      do_reset();
      port_enable = 2'b01;
      pk_q[0] = '{4, 2};
      en_clr_at = 1;
      run(100);
      repeat (5) begin
         @(negedge clk);
         drive();
         #1;
         check_update(1'b0);
      end
      chk("en_cnt0", cnt0, 1);
      chk("en_grant", grant, 2'b00);
      chk("en_pending0", pk_q[0].size(), 1);

      // Downstream ready toggling every cycle
      do_reset();
      port_enable = 2'b11;
      rdy_mode = 1;
      pk_q[0] = '{4};
      pk_q[1] = '{3};
      run(100);
      chk("tog_cnt0", cnt0, 1);
      chk("tog_cnt1", cnt1, 1);

      // Counter wrap from a preloaded 0xFFFFFFFF
      do_reset();
      @(negedge clk);
      force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.pkt_cnt0_q;
      mdl_cnt[0] = 32'hFFFF_FFFF;
      port_enable = 2'b11;
      pk_q[0] = '{2};
      run(50);
      chk("wrap_cnt0", cnt0, 32'h0000_0000);

      // Reset during beat 2 of port 1's second packet
      do_reset();
      port_enable = 2'b10;
      pk_q[0] = '{3};
      pk_q[1] = '{2, 4};
      rst_at = 1;
      rst_fired = 0;
      run(100);
      chk("rst_fired", rst_fired, 1'b1);
      chk("rst_first_after", (served.size() > 0) ? served[0] : -1, 0);
      chk("rst_cnt0", cnt0, 1);
      chk("rst_cnt1", cnt1, 1);

      // Random traffic: valid gaps, random ready, random lengths
      do_reset();
      port_enable = 2'b11;
      vld_rand = 1;
      rdy_mode = 2;
      for (int i = 0; i < 10; i++) begin
         pk_q[0].push_back($urandom_range(1, 5));
         pk_q[1].push_back($urandom_range(1, 5));
      end
      run(3000);
      chk("rand_cnt0", cnt0, 10);
      chk("rand_cnt1", cnt1, 10);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
